// File: rtl/sm_bin2bcd_seq.sv
// sm_bin2bcd_seq
// Sequential double-dabble converter: unsigned binary in, packed BCD out.
// One shift-and-add-3 iteration per clock. A new value is accepted through a
// valid/ready handshake. The result and its overflow flag are held until the
// next conversion finishes, so a display driver can sample them at any time.
// Values too large for DIGITS decimal digits saturate to all nines and set
// the overflow flag.

module sm_bin2bcd_seq #(
    parameter int WIDTH  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  overflow
);

    localparam int SCRATCH_W = DIGITS * 4 + WIDTH;
    localparam int CNT_W     = $clog2(WIDTH + 1);

    // Largest value that still fits in DIGITS decimal digits (10^DIGITS - 1).
    // It is evaluated at 64-bit precision, so WIDTH must not exceed 64.
    function automatic logic [63:0] maxDecimal(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = maxDecimal(DIGITS);

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic                   w_load;
    logic                   w_done;
    logic                   w_ovf;
    logic [SCRATCH_W-1:0]   r_scratch;
    logic [SCRATCH_W-1:0]   w_adj;
    logic [SCRATCH_W-1:0]   w_shifted;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovfPend;
    logic [DIGITS*4-1:0]    r_bcd;
    logic                   r_bcdValid;
    logic                   r_overflow;

    // The state register. Reset always returns the converter to IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and handshake decode. The converter is ready only in
    // IDLE. The final iteration is the one where the counter is at 1.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // A single double-dabble step. Every BCD nibble of 5 or more gets +3,
    // and then the whole scratch register shifts left by one. A nibble is
    // at most 9 before the add, so the 4-bit add never carries out.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[WIDTH + 4*d +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*d +: 4] = r_scratch[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        w_shifted = w_adj << 1;
        w_ovf     = (64'(in_bin) > MAX_DEC);
    end

    // Datapath. Load on a transfer, iterate while shifting, and publish the
    // result on the last iteration. When the input overflowed, the raw
    // shifted value is truncated garbage, so it is replaced by all nines.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovfPend  <= 1'b0;
            r_bcd      <= '0;
            r_bcdValid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_bcdValid <= 1'b0;
            if (w_load) begin
                r_scratch <= {{(DIGITS*4){1'b0}}, in_bin};
                r_cnt     <= CNT_W'(WIDTH);
                r_ovfPend <= w_ovf;
            end else if (r_state == SHIFT) begin
                r_scratch <= w_shifted;
                r_cnt     <= r_cnt - CNT_W'(1);
                if (w_done) begin
                    r_bcd      <= r_ovfPend ? {DIGITS{4'h9}}
                                            : w_shifted[SCRATCH_W-1:WIDTH];
                    r_overflow <= r_ovfPend;
                    r_bcdValid <= 1'b1;
                end
            end
        end
    end

    assign bcd       = r_bcd;
    assign bcd_valid = r_bcdValid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_sm_bin2bcd_seq.sv
// tb_sm_bin2bcd_seq
// Directed table of conversions with hand-computed BCD, followed by the
// held-valid, mid-conversion reset and random sequences, which are checked
// against a decimal reference model.

module tb_sm_bin2bcd_seq;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_bin;
    logic [31:0] bcd;
    logic        bcd_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] prevBcd;
    logic        prevOvf;

    typedef struct {
        logic [26:0] inBin;
        logic [31:0] expBcd;
        logic        expOvf;
    } vec_t;

    vec_t vecs[10];

    sm_bin2bcd_seq #(.WIDTH(27), .DIGITS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .overflow  (overflow)
    );

    // Free-running 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Guard against a hang anywhere in the sequence.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not end, required finish before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference decimal model, saturating at 99_999_999.
    function automatic logic [31:0] refBcd(input logic [26:0] v);
        logic [31:0] r;
        int unsigned n;
        n = 32'(v);
        r = '0;
        if (n > 99_999_999) begin
            r = 32'h99999999;
        end else begin
            for (int d = 0; d < 8; d++) begin
                r[4*d +: 4] = 4'(n % 10);
                n = n / 10;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs from 1 ns after a rising edge. Waits for in_ready, presents the
    // value, and returns 1 ns after the transfer edge with in_valid dropped.
    task automatic applyStimulus(input logic [26:0] value);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 60) begin
            @(posedge clock);
            #1;
            w++;
        end
        checkOutput("ready_before_transfer", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_bin   = value;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_bin   = 27'($urandom);
    endtask

    task automatic runVector(input string name, input logic [26:0] value,
                             input logic [31:0] expBcd, input logic expOvf);
        int lat;
        bit seen;
        bit holdBad;
        bit readyBad;
        applyStimulus(value);
        lat      = 0;
        seen     = 1'b0;
        holdBad  = 1'b0;
        readyBad = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clock);
            #1;
            if (bcd_valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                if (bcd !== prevBcd || overflow !== prevOvf) holdBad = 1'b1;
                if (in_ready !== 1'b0) readyBad = 1'b1;
            end
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'd27);
        checkOutput({name, "_bcd"}, 64'(bcd), 64'(expBcd));
        checkOutput({name, "_overflow"}, 64'(overflow), 64'(expOvf));
        checkOutput({name, "_held_between_pulses"}, 64'(holdBad), 64'd0);
        checkOutput({name, "_ready_low_while_busy"}, 64'(readyBad), 64'd0);
        checkOutput({name, "_ready_in_pulse_cycle"}, 64'(in_ready), 64'd1);
        prevBcd = expBcd;
        prevOvf = expOvf;
    endtask

    initial begin
        vecs[0] = '{27'd0,           32'h00000000, 1'b0};
        vecs[1] = '{27'd12_345_678,  32'h12345678, 1'b0};
        vecs[2] = '{27'd99_999_999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd9,           32'h00000009, 1'b0};
        vecs[4] = '{27'd100_000_000, 32'h99999999, 1'b1};
        vecs[5] = '{27'd42,          32'h00000042, 1'b0};
        vecs[6] = '{27'd134_217_727, 32'h99999999, 1'b1};
        vecs[7] = '{27'd10,          32'h00000010, 1'b0};
        vecs[8] = '{27'd80_706_050,  32'h80706050, 1'b0};
        vecs[9] = '{27'd5,           32'h00000005, 1'b0};

        prevBcd  = '0;
        prevOvf  = 1'b0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bin   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_bcd", 64'(bcd), 64'd0);
        checkOutput("reset_bcd_valid", 64'(bcd_valid), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);

        // The first conversion also confirms that the valid pulse lasts one cycle.
        runVector("zero", vecs[0].inBin, vecs[0].expBcd, vecs[0].expOvf);
        @(posedge clock);
        #1;
        checkOutput("pulse_width", 64'(bcd_valid), 64'd0);
        checkOutput("bcd_held_after_pulse", 64'(bcd), 64'h0);

        for (int i = 1; i < 10; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i].inBin, vecs[i].expBcd, vecs[i].expOvf);
        end

        // Hold in_valid with a wandering in_bin; only the value at each transfer counts.
        begin
            int lat1;
            int lat2;
            bit seen;
            in_valid = 1'b1;
            in_bin   = 27'd31_415_926;
            @(posedge clock);
            #1;
            lat1 = 0;
            seen = 1'b0;
            for (int c = 1; c <= 40 && !seen; c++) begin
                in_bin = 27'($urandom);
                @(posedge clock);
                #1;
                if (bcd_valid === 1'b1) begin
                    seen = 1'b1;
                    lat1 = c;
                end
            end
            checkOutput("hold_first_latency", 64'(lat1), 64'd27);
            checkOutput("hold_first_bcd", 64'(bcd), 64'h31415926);
            in_bin = 27'd27_182_818;
            lat2 = 0;
            seen = 1'b0;
            for (int c = 1; c <= 40 && !seen; c++) begin
                @(posedge clock);
                #1;
                in_bin = 27'($urandom);
                if (bcd_valid === 1'b1) begin
                    seen = 1'b1;
                    lat2 = c;
                end
            end
            in_valid = 1'b0;
            checkOutput("hold_pulse_spacing", 64'(lat2), 64'd28);
            checkOutput("hold_second_bcd", 64'(bcd), 64'h27182818);
            checkOutput("hold_second_overflow", 64'(overflow), 64'd0);
            prevBcd = 32'h27182818;
            prevOvf = 1'b0;
            @(posedge clock);
            #1;
        end

        // Reset ten cycles into a conversion aborts it.
        begin
            bit pulseSeen;
            applyStimulus(27'd55_555_555);
            repeat (9) @(posedge clock);
            #1;
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            checkOutput("abort_bcd", 64'(bcd), 64'd0);
            checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
            checkOutput("abort_overflow", 64'(overflow), 64'd0);
            pulseSeen = (bcd_valid === 1'b1);
            for (int c = 0; c < 30; c++) begin
                @(posedge clock);
                #1;
                if (bcd_valid !== 1'b0) pulseSeen = 1'b1;
            end
            checkOutput("abort_no_pulse", 64'(pulseSeen), 64'd0);
            prevBcd = '0;
            prevOvf = 1'b0;
            runVector("after_abort", 27'd7, 32'h00000007, 1'b0);
        end

        // Random values across the whole input range, including saturation.
        for (int i = 0; i < 300; i++) begin
            logic [26:0] v;
            v = 27'($urandom_range(134_217_727, 0));
            runVector($sformatf("rand%0d", i), v, refBcd(v), v > 27'd99_999_999);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
